// File: rtl/smart_toilet_pkg.sv
// Shared types and constants for the smart-toilet actuator control slice.
// Arbiter FSM codes, valve selector codes and requester indices.
package smart_toilet_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StDead  = 2'd2
  } arb_state_e;

  localparam logic [1:0] VALVE_NONE  = 2'd0;
  localparam logic [1:0] VALVE_SPRAY = 2'd1;
  localparam logic [1:0] VALVE_FLUSH = 2'd2;

  localparam int unsigned REQ_SPRAY = 0;
  localparam int unsigned REQ_FLUSH = 1;
  localparam int unsigned REQ_WARM  = 2;
  localparam int unsigned NUM_REQ   = 3;

endpackage

// File: rtl/cycle_timer.sv
// Up counter with synchronous clear and enable; done flags that the count equals limit.
// Shared by the arbiter for both the dead-time and the grant-timeout intervals.
module cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == limit);

endmodule

// File: rtl/water_res_arbiter.sv
// Exclusive arbiter for the pump/valve manifold (spray, flush) and the seat heater (warm),
// with round-robin water priority, dead time between owners and a bounded water grant.
module water_res_arbiter
  import smart_toilet_pkg::*;
#(
  parameter int unsigned DEAD_TIME = 4,
  parameter int unsigned MAX_GRANT = 200,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_spray,
  input  logic       req_flush,
  input  logic       req_warm,
  input  logic       clr_err,
  output logic       gnt_spray,
  output logic       gnt_flush,
  output logic       gnt_warm,
  output logic       pump_on,
  output logic       heater_on,
  output logic [1:0] valve_sel,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] DeadLast  = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] GrantLast = CNT_W'(MAX_GRANT - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] req_raw, req_eff, pick;
  logic [1:0]         mask_q, mask_d;
  logic               ptr_q, ptr_d;  // 1: flush wins the next spray/flush tie
  logic               err_q, err_d;
  logic               owner_req, water_owner, water_req, timeout_hit, preempt;
  logic               timer_clr, timer_done;
  logic [CNT_W-1:0]   timer_limit;

  assign req_raw[REQ_SPRAY] = req_spray;
  assign req_raw[REQ_FLUSH] = req_flush;
  assign req_raw[REQ_WARM]  = req_warm;

  assign req_eff[REQ_SPRAY] = req_spray & ~mask_q[REQ_SPRAY];
  assign req_eff[REQ_FLUSH] = req_flush & ~mask_q[REQ_FLUSH];
  assign req_eff[REQ_WARM]  = req_warm;

  assign water_req   = req_eff[REQ_SPRAY] | req_eff[REQ_FLUSH];
  assign owner_req   = |(gnt_q & req_raw);
  assign water_owner = gnt_q[REQ_SPRAY] | gnt_q[REQ_FLUSH];
  assign timeout_hit = (state_q == StGrant) & water_owner & owner_req & timer_done;
  assign preempt     = gnt_q[REQ_WARM] & water_req;

  // Timer restarts on every state change and idles at zero in StIdle.
  assign timer_clr   = (state_q == StIdle) || (state_d != state_q);
  assign timer_limit = (state_q == StDead) ? DeadLast : GrantLast;

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (timer_clr),
    .en     (1'b1),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  always_comb begin
    pick = '0;
    if (req_eff[REQ_SPRAY] && req_eff[REQ_FLUSH]) begin
      if (ptr_q) begin
        pick[REQ_FLUSH] = 1'b1;
      end else begin
        pick[REQ_SPRAY] = 1'b1;
      end
    end else if (req_eff[REQ_SPRAY]) begin
      pick[REQ_SPRAY] = 1'b1;
    end else if (req_eff[REQ_FLUSH]) begin
      pick[REQ_FLUSH] = 1'b1;
    end else if (req_eff[REQ_WARM]) begin
      pick[REQ_WARM] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (|req_eff) state_d = StGrant;
      StGrant: if (!owner_req || timeout_hit || preempt) state_d = StDead;
      StDead:  if (timer_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    mask_d[REQ_SPRAY] = mask_q[REQ_SPRAY] & req_spray;
    mask_d[REQ_FLUSH] = mask_q[REQ_FLUSH] & req_flush;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
      mask_d[REQ_SPRAY] = mask_d[REQ_SPRAY] | gnt_q[REQ_SPRAY];
      mask_d[REQ_FLUSH] = mask_d[REQ_FLUSH] | gnt_q[REQ_FLUSH];
    end
    if (state_q == StIdle && state_d == StGrant) begin
      gnt_d = pick;
      if (pick[REQ_SPRAY]) begin
        ptr_d = 1'b1;
      end else if (pick[REQ_FLUSH]) begin
        ptr_d = 1'b0;
      end
    end else if (state_d == StDead) begin
      gnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q  <= '0;
      ptr_q  <= 1'b0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign gnt_spray   = gnt_q[REQ_SPRAY];
  assign gnt_flush   = gnt_q[REQ_FLUSH];
  assign gnt_warm    = gnt_q[REQ_WARM];
  assign pump_on     = gnt_q[REQ_SPRAY] | gnt_q[REQ_FLUSH];
  assign heater_on   = gnt_q[REQ_WARM];
  assign valve_sel   = gnt_q[REQ_SPRAY] ? VALVE_SPRAY :
                       gnt_q[REQ_FLUSH] ? VALVE_FLUSH : VALVE_NONE;
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_water_res_arbiter.sv
// Self-checking bench for water_res_arbiter: directed scenarios plus random requests,
// compared every cycle against a timestamp-based reference model.
module tb_water_res_arbiter;

  localparam int DT = 4;
  localparam int MG = 200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_spray = 1'b0, req_flush = 1'b0, req_warm = 1'b0, clr_err = 1'b0;
  logic       gnt_spray, gnt_flush, gnt_warm, pump_on, heater_on, busy, timeout_err;
  logic [1:0] valve_sel;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int who, n, gi, high;

  // Reference model: current owner (-1 none, 0 spray, 1 flush, 2 warm), edge of grant,
  // earliest edge at which a new grant may be issued.
  int m_owner = -1;
  int m_gedge = 0;
  int m_next_ok = 0;
  bit m_ptr = 1'b0;
  bit m_err = 1'b0;
  bit m_mask[2];

  water_res_arbiter #(
    .DEAD_TIME(DT),
    .MAX_GRANT(MG),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_spray  (req_spray),
    .req_flush  (req_flush),
    .req_warm   (req_warm),
    .clr_err    (clr_err),
    .gnt_spray  (gnt_spray),
    .gnt_flush  (gnt_flush),
    .gnt_warm   (gnt_warm),
    .pump_on    (pump_on),
    .heater_on  (heater_on),
    .valve_sel  (valve_sel),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_next_ok = 0;
    m_ptr = 1'b0;
    m_err = 1'b0;
    m_mask[0] = 1'b0;
    m_mask[1] = 1'b0;
  endtask

  task automatic model_edge();
    bit req[3];
    bit eff_s, eff_f, rel, to;
    req[0] = req_spray;
    req[1] = req_flush;
    req[2] = req_warm;
    eff_s = req_spray && !m_mask[0];
    eff_f = req_flush && !m_mask[1];
    for (int i = 0; i < 2; i++) if (!req[i]) m_mask[i] = 1'b0;
    if (clr_err) m_err = 1'b0;
    if (m_owner >= 0) begin
      to  = (m_owner < 2) && req[m_owner] && (t - m_gedge == MG);
      rel = !req[m_owner] || to || (m_owner == 2 && (eff_s || eff_f));
      if (to) begin
        m_err = 1'b1;
        m_mask[m_owner] = 1'b1;
      end
      if (rel) begin
        m_owner = -1;
        m_next_ok = t + 1 + DT;
      end
    end else if (t >= m_next_ok) begin
      if (eff_s && eff_f) m_owner = m_ptr ? 1 : 0;
      else if (eff_s) m_owner = 0;
      else if (eff_f) m_owner = 1;
      else if (req_warm) m_owner = 2;
      if (m_owner == 0 || m_owner == 1) begin
        m_ptr = (m_owner == 0);
        m_gedge = t;
      end
    end
  endtask

  function automatic logic [8:0] exp_vec();
    logic gs, gf, gw, b;
    logic [1:0] v;
    gs = (m_owner == 0);
    gf = (m_owner == 1);
    gw = (m_owner == 2);
    v  = gs ? 2'd1 : (gf ? 2'd2 : 2'd0);
    b  = (m_owner >= 0) || (t + 1 < m_next_ok);
    return {gs, gf, gw, gs | gf, gw, v, b, m_err};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {gnt_spray, gnt_flush, gnt_warm, pump_on, heater_on, valve_sel, busy, timeout_err};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk($sformatf("cycle%0d", t), 32'(obs_vec()), 32'(exp_vec()));
    chk("exclusive", 32'($countones({gnt_spray, gnt_flush, gnt_warm}) <= 1), 32'd1);
    t++;
  endtask

  task automatic wait_grant(output int w);
    w = -1;
    for (int i = 0; i < 60 && w < 0; i++) begin
      step();
      if (gnt_spray === 1'b1) w = 0;
      else if (gnt_flush === 1'b1) w = 1;
      else if (gnt_warm === 1'b1) w = 2;
    end
  endtask

  task automatic drain();
    req_spray = 1'b0;
    req_flush = 1'b0;
    req_warm  = 1'b0;
    repeat (DT + 3) step();
  endtask

  initial begin
    model_reset();
    // 1: reset with every request high
    req_spray = 1'b1;
    req_flush = 1'b1;
    req_warm  = 1'b1;
    #1;
    chk("t1_reset_t0", 32'(obs_vec()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_reset_held", 32'(obs_vec()), 32'd0);
    reset_n = 1'b1;
    step();
    chk("t1_first_grant", 32'(gnt_spray), 32'd1);

    // 2: release and dead time, spray -> flush
    req_warm = 1'b0;
    step();
    chk("t2_valve_spray", 32'(valve_sel), 32'd1);
    req_spray = 1'b0;
    step();
    chk("t2_spray_drop", 32'(gnt_spray), 32'd0);
    chk("t2_valve_closed", 32'(valve_sel), 32'd0);
    n = 1;
    while (gnt_flush !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("t2_flush_latency", 32'(n), 32'(DT + 2));
    chk("t2_valve_flush", 32'(valve_sel), 32'd2);
    drain();

    // 3: round-robin with both water requests held
    req_spray = 1'b1;
    req_flush = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_grant(who);
      chk($sformatf("t3_order%0d", g), 32'(who), 32'(g % 2));
      repeat (9) step();
      if (who == 0) req_spray = 1'b0;
      if (who == 1) req_flush = 1'b0;
      step();
      req_spray = 1'b1;
      req_flush = 1'b1;
    end
    drain();

    // 4: warm preempted by spray
    req_warm = 1'b1;
    wait_grant(who);
    chk("t4_warm_grant", 32'(who), 32'd2);
    repeat (19) step();
    req_spray = 1'b1;
    step();
    chk("t4_warm_drop", 32'(gnt_warm), 32'd0);
    n = 0;
    while (gnt_spray !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("t4_spray_latency", 32'(n), 32'(DT + 1));
    drain();

    // 5: flush timeout, with clr_err coinciding with the timeout edge
    req_flush = 1'b1;
    gi = -1;
    high = 0;
    for (int i = 0; i < 250; i++) begin
      clr_err = (gi >= 0 && i == gi + MG);
      step();
      clr_err = 1'b0;
      if (gnt_flush === 1'b1) begin
        high++;
        if (gi < 0) gi = i;
      end
    end
    chk("t5_grant_len", 32'(high), 32'(MG));
    chk("t5_set_wins", 32'(timeout_err), 32'd1);
    req_flush = 1'b0;
    step();
    step();
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t5_err_clear", 32'(timeout_err), 32'd0);
    req_flush = 1'b1;
    wait_grant(who);
    chk("t5_regrant", 32'(who), 32'd1);
    drain();

    // random requests
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) req_spray = ~req_spray;
      if ($urandom_range(0, 11) == 0) req_flush = ~req_flush;
      if ($urandom_range(0, 11) == 0) req_warm = ~req_warm;
      clr_err = ($urandom_range(0, 40) == 0);
      step();
    end
    clr_err = 1'b0;
    drain();

    // 6: async reset mid-spray; pointer returns to spray
    req_spray = 1'b1;
    wait_grant(who);
    chk("t6_spray_grant", 32'(who), 32'd0);
    req_flush = 1'b1;
    repeat (3) step();
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_pump_async", 32'(pump_on), 32'd0);
    chk("t6_outputs_async", 32'(obs_vec()), 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk("t6_ptr_reset", 32'(gnt_spray), 32'd1);
    repeat (3) step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
